hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central pipeline interlock for the 5-stage core; successor to the single-cycle load-use detector.
//  Adds: configurable load-use latency, per-operand use qualification, mult/div busy interlock,
//  data-memory wait freeze, taken-branch flush, cause reporting and a saturating stall counter.
//  Sits beside the ID stage and drives PC/IF-ID write enables, bubble insertion and flushes.
// PARAMETERS
//  REG_AW      5   register-index width
//  LOAD_LAT    1   bubbles needed after a load before a dependent use (1..7)
//  MD_CYCLES   32  cycles mult/div unit is busy after start (2..63)
//  CNT_W       16  width of stall performance counter
// PORTS
//  clock          in   1       core clock
//  reset_n        in   1       asynchronous active-low reset
//  id_rs          in   REG_AW  ID source register rs
//  id_rt          in   REG_AW  ID source register rt
//  id_rs_used     in   1       ID instruction actually reads rs
//  id_rt_used     in   1       ID instruction actually reads rt
//  id_hilo_read   in   1       ID instruction is mfhi/mflo
//  id_md_start    in   1       ID instruction is mult/multu/div/divu
//  ex_MemRead     in   1       EX instruction is a load
//  ex_rt          in   REG_AW  EX load destination
//  ex_md_start    in   1       mult/div entering EX (starts busy period)
//  ex_branch_taken in  1       branch/jump resolved taken in EX
//  mem_access     in   1       MEM stage performing load/store
//  mem_ready      in   1       data memory completes access this cycle
//  PC_IFWrite     out  1       1 = PC and IF/ID may update
//  ID_EX_stall    out  1       1 = load bubble into ID/EX
//  IF_ID_flush    out  1       1 = kill IF/ID contents
//  EX_MEM_hold    out  1       1 = freeze EX/MEM and MEM/WB
//  hz_cause       out  3       {mem_wait, md_busy, load_use}, one-hot or 0
//  stall_cnt      out  CNT_W   cycles with PC_IFWrite==0, saturating
// BEHAVIOUR
//  - Register index 0 never causes a hazard; operand matches only when its *_used is 1.
//  - load_use_hit = ex_MemRead & ex_rt!=0 & ((id_rs_used & id_rs==ex_rt) | (id_rt_used & id_rt==ex_rt)).
//  - lu_cnt (3b): on load_use_hit with lu_cnt==0 and no freeze/flush, load LOAD_LAT-1; decrement while >0
//    and not frozen. Load-use stall active = load_use_hit | lu_cnt!=0 -> exactly LOAD_LAT bubbles.
//  - md_cnt (6b): ex_md_start (not frozen) loads MD_CYCLES-1; decrements to 0 while not frozen.
//    md stall = md_cnt!=0 & (id_hilo_read | id_md_start).
//  - mem_wait = mem_access & ~mem_ready.
//  - Priority per cycle, all outputs combinational from state+inputs:
//    1 mem_wait: PC_IFWrite=0, EX_MEM_hold=1, ID_EX_stall=0, IF_ID_flush=0, counters hold, hz_cause=100.
//    2 ex_branch_taken: IF_ID_flush=1, ID_EX_stall=1 (bubble replaces killed ID instr), PC_IFWrite=1,
//      lu_cnt cleared to 0, md_cnt unaffected, hz_cause=000.
//    3 md stall: PC_IFWrite=0, ID_EX_stall=1, hz_cause=010.
//    4 load-use stall: PC_IFWrite=0, ID_EX_stall=1, hz_cause=001.
//    else PC_IFWrite=1, others 0.
//  - Flush delayed by mem_wait reasserts automatically when mem_ready rises (EX held, input persists).
//  - stall_cnt increments each cycle PC_IFWrite==0; sticks at all-ones.
//  - Reset (async, any time, incl. mid-stall): lu_cnt=0, md_cnt=0, stall_cnt=0; outputs then
//    PC_IFWrite=1, ID_EX_stall=0, IF_ID_flush=0, EX_MEM_hold=0, hz_cause=0 unless inputs request stall.
//  - LOAD_LAT=1 reproduces legacy behaviour exactly when *_used tied 1 and other inputs 0.
// STRUCTURE
//  - Shared package core_pkg: REG_AW default, hz_cause bit positions (HZ_LU=0, HZ_MD=1, HZ_MEM=2).
//  - One sub-module: hz_down_counter (load, dec-enable, clear, zero flag; width param), used for
//    lu_cnt and md_cnt. Everything else flat in this module.
// TESTING
//  - LOAD_LAT=1: ex_MemRead=1, ex_rt=8, id_rs=8 used -> 1 cycle PC_IFWrite=0, ID_EX_stall=1, cause=001.
//  - LOAD_LAT=3: same hit -> 3 consecutive bubbles, stall_cnt=3; id_rt=8 with id_rt_used=0 -> no stall.
//  - ex_rt=0, id_rs=0 with ex_MemRead=1 -> no stall; ex_md_start then id_hilo_read next cycle ->
//    stall MD_CYCLES-1 cycles, cause=010, released when md_cnt reaches 0.
//  - mem_access=1, mem_ready=0 for 4 cycles with ex_branch_taken=1 -> EX_MEM_hold=1 4 cycles, no flush;
//    cycle mem_ready=1 -> IF_ID_flush=1, PC_IFWrite=1.
//  - LOAD_LAT=3 stall in progress, ex_branch_taken=1 -> flush, lu_cnt=0, next cycle PC_IFWrite=1.
//  - reset_n low mid md stall -> counters 0 asynchronously, stall_cnt=0; stall_cnt saturation with CNT_W=4.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: default register-index width, hazard cause bit
// positions and the priority-resolved hazard class used by the interlock.
package core_pkg;

  localparam int REG_AW_DEF = 5;

  // hz_cause bit positions
  localparam int HZ_LU  = 0;
  localparam int HZ_MD  = 1;
  localparam int HZ_MEM = 2;
  localparam int HZ_W   = 3;

  // Winning hazard for the current cycle after priority resolution
  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_MEM_WAIT = 3'd1,
    SEL_FLUSH    = 3'd2,
    SEL_MD_STALL = 3'd3,
    SEL_LU_STALL = 3'd4
  } hz_sel_e;

  function automatic logic [HZ_W-1:0] cause_bit(input int pos);
    logic [HZ_W-1:0] v;
    v      = '0;
    v[pos] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hz_down_counter.sv
// Small down-counter with clear, load and decrement-enable; stops at zero.
// Clear wins over load, load wins over decrement.
module hz_down_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Counter register: clear / load / decrement toward zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock beside the ID stage: load-use bubbles with configurable
// latency, mult/div busy interlock, data-memory wait freeze, taken-branch
// flush, hazard cause reporting and a saturating stall counter.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int LOAD_LAT  = 1,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_hilo_read,
  input  logic              id_md_start,
  input  logic              ex_MemRead,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_md_start,
  input  logic              ex_branch_taken,
  input  logic              mem_access,
  input  logic              mem_ready,
  output logic              PC_IFWrite,
  output logic              ID_EX_stall,
  output logic              IF_ID_flush,
  output logic              EX_MEM_hold,
  output logic [HZ_W-1:0]   hz_cause,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [2:0]       LU_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [5:0]       MD_RELOAD = 6'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       mem_wait;
  logic       rs_match;
  logic       rt_match;
  logic       load_use_hit;
  logic       md_stall;
  logic       lu_stall;
  logic [2:0] lu_cnt;
  logic       lu_zero;
  logic [5:0] md_cnt;
  logic       md_zero;
  hz_sel_e    sel;

  assign mem_wait     = mem_access & ~mem_ready;
  assign rs_match     = id_rs_used & (id_rs == ex_rt);
  assign rt_match     = id_rt_used & (id_rt == ex_rt);
  assign load_use_hit = ex_MemRead & (ex_rt != '0) & (rs_match | rt_match);
  assign md_stall     = ~md_zero & (id_hilo_read | id_md_start);
  assign lu_stall     = load_use_hit | ~lu_zero;

  // Remaining load-use bubbles after the first; a taken branch kills the
  // dependent instruction, so the pending bubbles are dropped.
  hz_down_counter #(.W(3)) u_lu_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (~mem_wait & ex_branch_taken),
    .load     (~mem_wait & load_use_hit & lu_zero),
    .load_val (LU_RELOAD),
    .dec_en   (~mem_wait),
    .cnt      (lu_cnt),
    .zero     (lu_zero)
  );

  // Mult/div busy window, started when the operation enters EX
  hz_down_counter #(.W(6)) u_md_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (1'b0),
    .load     (~mem_wait & ex_md_start),
    .load_val (MD_RELOAD),
    .dec_en   (~mem_wait),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );

  // Resolve which hazard owns this cycle, highest priority first
  always_comb begin
    sel = SEL_NONE;
    if (mem_wait) begin
      sel = SEL_MEM_WAIT;
    end else if (ex_branch_taken) begin
      sel = SEL_FLUSH;
    end else if (md_stall) begin
      sel = SEL_MD_STALL;
    end else if (lu_stall) begin
      sel = SEL_LU_STALL;
    end
  end

  // Pipeline control outputs for the selected hazard
  always_comb begin
    PC_IFWrite  = 1'b1;
    ID_EX_stall = 1'b0;
    IF_ID_flush = 1'b0;
    EX_MEM_hold = 1'b0;
    hz_cause    = '0;
    case (sel)
      SEL_MEM_WAIT: begin
        PC_IFWrite  = 1'b0;
        EX_MEM_hold = 1'b1;
        hz_cause    = cause_bit(HZ_MEM);
      end
      SEL_FLUSH: begin
        // the killed ID instruction is replaced by a bubble
        IF_ID_flush = 1'b1;
        ID_EX_stall = 1'b1;
      end
      SEL_MD_STALL: begin
        PC_IFWrite  = 1'b0;
        ID_EX_stall = 1'b1;
        hz_cause    = cause_bit(HZ_MD);
      end
      SEL_LU_STALL: begin
        PC_IFWrite  = 1'b0;
        ID_EX_stall = 1'b1;
        hz_cause    = cause_bit(HZ_LU);
      end
      default: ;
    endcase
  end

  // Saturating count of cycles in which fetch was held
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (!PC_IFWrite && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three parameterisations driven in
// lockstep, compared every cycle against an abstract reference model, plus a
// vector table and hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       hilo;
    logic       idmd;
    logic       memread;
    logic [4:0] ex_rt;
    logic       md_start;
    logic       branch;
    logic       macc;
    logic       mrdy;
  } in_t;

  typedef struct {
    in_t        i;
    logic [6:0] exp;  // {pc, idex, flush, hold, cause[2:0]}
  } vec_t;

  logic       clock;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_rs_used, id_rt_used, id_hilo_read, id_md_start;
  logic       ex_MemRead, ex_md_start, ex_branch_taken, mem_access, mem_ready;

  logic       pc_o    [3];
  logic       idex_o  [3];
  logic       flush_o [3];
  logic       hold_o  [3];
  logic [2:0] cause_o [3];
  logic [15:0] sc_a, sc_b;
  logic [3:0]  sc_c;

  int ntests = 0;
  int nfail  = 0;

  // model parameters and state per instance
  int lat  [3] = '{1, 3, 3};
  int mdc  [3] = '{32, 32, 5};
  int cmax [3] = '{65535, 65535, 15};
  int m_lu [3];
  int m_md [3];
  int m_sc [3];
  logic [6:0] last_out [3];

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .MD_CYCLES(32), .CNT_W(16)) dut_a (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_hilo_read(id_hilo_read),
    .id_md_start(id_md_start), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .PC_IFWrite(pc_o[0]), .ID_EX_stall(idex_o[0]), .IF_ID_flush(flush_o[0]),
    .EX_MEM_hold(hold_o[0]), .hz_cause(cause_o[0]), .stall_cnt(sc_a));

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MD_CYCLES(32), .CNT_W(16)) dut_b (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_hilo_read(id_hilo_read),
    .id_md_start(id_md_start), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .PC_IFWrite(pc_o[1]), .ID_EX_stall(idex_o[1]), .IF_ID_flush(flush_o[1]),
    .EX_MEM_hold(hold_o[1]), .hz_cause(cause_o[1]), .stall_cnt(sc_b));

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MD_CYCLES(5), .CNT_W(4)) dut_c (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_hilo_read(id_hilo_read),
    .id_md_start(id_md_start), .ex_MemRead(ex_MemRead), .ex_rt(ex_rt),
    .ex_md_start(ex_md_start), .ex_branch_taken(ex_branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .PC_IFWrite(pc_o[2]), .ID_EX_stall(idex_o[2]), .IF_ID_flush(flush_o[2]),
    .EX_MEM_hold(hold_o[2]), .hz_cause(cause_o[2]), .stall_cnt(sc_c));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] get_out(input int k);
    return {pc_o[k], idex_o[k], flush_o[k], hold_o[k], cause_o[k]};
  endfunction

  function automatic logic [31:0] get_sc(input int k);
    case (k)
      0:       return {16'd0, sc_a};
      1:       return {16'd0, sc_b};
      default: return {28'd0, sc_c};
    endcase
  endfunction

  function automatic in_t mk(input int rs, rt, rsu, rtu, hilo, idmd, mr, exrt,
                             mds, br, macc, mrdy);
    in_t x;
    x.rs = 5'(rs);  x.rt = 5'(rt);
    x.rs_used = 1'(rsu);  x.rt_used = 1'(rtu);
    x.hilo = 1'(hilo);  x.idmd = 1'(idmd);
    x.memread = 1'(mr);  x.ex_rt = 5'(exrt);
    x.md_start = 1'(mds);  x.branch = 1'(br);
    x.macc = 1'(macc);  x.mrdy = 1'(mrdy);
    return x;
  endfunction

  function automatic bit is_hit(input in_t x);
    return x.memread && (x.ex_rt != 0) &&
           ((x.rs_used && x.rs == x.ex_rt) || (x.rt_used && x.rt == x.ex_rt));
  endfunction

  // Reference: outputs from priority rules over abstract bubble / busy counts
  function automatic logic [6:0] model_out(input int k, input in_t x);
    if (x.macc && !x.mrdy)                  return 7'b0001100;
    if (x.branch)                           return 7'b1110000;
    if (m_md[k] > 0 && (x.hilo || x.idmd))  return 7'b0100010;
    if (is_hit(x) || m_lu[k] > 0)           return 7'b0100001;
    return 7'b1000000;
  endfunction

  task automatic model_update(input in_t x);
    logic [6:0] o;
    for (int k = 0; k < 3; k++) begin
      o = model_out(k, x);
      if (o[6] == 1'b0 && m_sc[k] < cmax[k]) m_sc[k]++;
      if (!(x.macc && !x.mrdy)) begin
        if (x.branch)           m_lu[k] = 0;
        else if (m_lu[k] > 0)   m_lu[k]--;
        else if (is_hit(x))     m_lu[k] = lat[k] - 1;
        if (x.md_start)         m_md[k] = mdc[k] - 1;
        else if (m_md[k] > 0)   m_md[k]--;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_lu[k] = 0; m_md[k] = 0; m_sc[k] = 0;
    end
  endtask

  task automatic drive(input in_t x);
    id_rs = x.rs;  id_rt = x.rt;
    id_rs_used = x.rs_used;  id_rt_used = x.rt_used;
    id_hilo_read = x.hilo;  id_md_start = x.idmd;
    ex_MemRead = x.memread;  ex_rt = x.ex_rt;
    ex_md_start = x.md_start;  ex_branch_taken = x.branch;
    mem_access = x.macc;  mem_ready = x.mrdy;
  endtask

  // one cycle: drive, sample at negedge against model, advance model at posedge
  task automatic step(input in_t x);
    drive(x);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      last_out[k] = get_out(k);
      chk($sformatf("model outputs dut%0d", k), {25'd0, last_out[k]}, {25'd0, model_out(k, x)});
      chk($sformatf("model stall_cnt dut%0d", k), get_sc(k), m_sc[k]);
    end
    @(posedge clock);
    model_update(x);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #2;
    reset_n = 1'b1;
  endtask

  vec_t tbl [12];
  in_t  z;
  in_t  x;
  int   cnt [3];

  initial begin
    z = '0;
    reset_n = 1'b0;
    drive(z);
    model_reset();
    #12;
    reset_n = 1'b1;

    // reset state
    step(z);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset outputs dut%0d", k), {25'd0, last_out[k]}, 32'h40);

    // vector table, checked on the LOAD_LAT=1 instance
    tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0,0,0,0), 7'b1000000};
    tbl[1]  = '{mk(8,0,1,0,0,0,1,8,0,0,0,0), 7'b0100001};
    tbl[2]  = '{mk(3,8,1,0,0,0,1,8,0,0,0,0), 7'b1000000};
    tbl[3]  = '{mk(3,8,1,1,0,0,1,8,0,0,0,0), 7'b0100001};
    tbl[4]  = '{mk(0,0,1,1,0,0,1,0,0,0,0,0), 7'b1000000};
    tbl[5]  = '{mk(0,0,0,0,0,0,0,0,0,1,0,0), 7'b1110000};
    tbl[6]  = '{mk(0,0,0,0,0,0,0,0,0,0,1,0), 7'b0001100};
    tbl[7]  = '{mk(0,0,0,0,0,0,0,0,0,0,1,1), 7'b1000000};
    tbl[8]  = '{mk(8,0,1,0,0,0,1,8,0,1,1,0), 7'b0001100};
    tbl[9]  = '{mk(8,0,1,0,0,0,1,8,0,1,0,0), 7'b1110000};
    tbl[10] = '{mk(0,0,0,0,1,1,0,0,0,0,0,0), 7'b1000000};
    tbl[11] = '{mk(5,5,0,1,0,0,1,5,0,0,0,0), 7'b0100001};
    for (int n = 0; n < 12; n++) begin
      step(tbl[n].i);
      chk($sformatf("table vec %0d", n), {25'd0, last_out[0]}, {25'd0, tbl[n].exp});
    end

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      x.rs       = 5'($urandom_range(0, 3));
      x.rt       = 5'($urandom_range(0, 3));
      x.rs_used  = 1'($urandom_range(0, 1));
      x.rt_used  = 1'($urandom_range(0, 1));
      x.hilo     = ($urandom_range(0, 3) == 0);
      x.idmd     = ($urandom_range(0, 7) == 0);
      x.memread  = ($urandom_range(0, 2) == 0);
      x.ex_rt    = 5'($urandom_range(0, 3));
      x.md_start = ($urandom_range(0, 15) == 0);
      x.branch   = ($urandom_range(0, 7) == 0);
      x.macc     = ($urandom_range(0, 2) == 0);
      x.mrdy     = 1'($urandom_range(0, 1));
      step(x);
    end

    // LOAD_LAT=3 produces three consecutive bubbles, LOAD_LAT=1 one
    do_reset();
    step(mk(8,0,1,0,0,0,1,8,0,0,0,0));
    chk("lu cycle0 dut_a pc", 32'(last_out[0][6]), 0);
    chk("lu cycle0 dut_b cause", 32'(last_out[1][2:0]), 1);
    for (int n = 1; n < 6; n++) begin
      step(mk(8,0,1,0,0,0,0,0,0,0,0,0));
      chk($sformatf("lu cycle%0d dut_a pc", n), 32'(last_out[0][6]), 1);
      chk($sformatf("lu cycle%0d dut_b pc", n), 32'(last_out[1][6]), (n < 3) ? 0 : 1);
    end
    chk("lu stall_cnt dut_a", get_sc(0), 1);
    chk("lu stall_cnt dut_b", get_sc(1), 3);

    // mult/div busy: hilo read stalls MD_CYCLES-1 cycles
    do_reset();
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0));
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    for (int n = 0; n < 40; n++) begin
      step(mk(0,0,0,0,1,0,0,0,0,0,0,0));
      for (int k = 0; k < 3; k++) if (last_out[k] == 7'b0100010) cnt[k]++;
    end
    chk("md stall cycles dut_a", cnt[0], 31);
    chk("md stall cycles dut_b", cnt[1], 31);
    chk("md stall cycles dut_c", cnt[2], 4);

    // mem wait delays a taken branch flush until mem_ready
    do_reset();
    for (int n = 0; n < 4; n++) begin
      step(mk(0,0,0,0,0,0,0,0,0,1,1,0));
      chk($sformatf("memwait %0d hold/flush", n), {30'd0, last_out[1][4:3]}, 32'b01);
    end
    step(mk(0,0,0,0,0,0,0,0,0,1,1,1));
    chk("memwait release flush/pc", {30'd0, last_out[1][6], last_out[1][4]}, 32'b11);

    // branch during a LOAD_LAT=3 stall drops the remaining bubbles
    do_reset();
    step(mk(8,0,1,0,0,0,1,8,0,0,0,0));
    step(mk(8,0,1,0,0,0,0,0,0,0,0,0));
    chk("lu+br stall pc", 32'(last_out[1][6]), 0);
    step(mk(8,0,1,0,0,0,0,0,0,1,0,0));
    chk("lu+br flush outputs", {25'd0, last_out[1]}, 32'b1110000);
    step(mk(8,0,1,0,0,0,0,0,0,0,0,0));
    chk("lu+br after pc", 32'(last_out[1][6]), 1);

    // async reset in the middle of a mult/div stall
    do_reset();
    step(mk(0,0,0,0,0,0,0,0,1,0,0,0));
    for (int n = 0; n < 3; n++) step(mk(0,0,0,0,1,0,0,0,0,0,0,0));
    reset_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("async rst stall_cnt dut%0d", k), get_sc(k), 0);
      chk($sformatf("async rst pc dut%0d", k), 32'(pc_o[k]), 1);
    end
    #1;
    reset_n = 1'b1;
    step(mk(0,0,0,0,1,0,0,0,0,0,0,0));
    chk("post rst hilo pc", 32'(last_out[1][6]), 1);

    // stall counter saturation
    do_reset();
    for (int n = 0; n < 20; n++) step(mk(0,0,0,0,0,0,0,0,0,0,1,0));
    chk("sat stall_cnt CNT_W=4", get_sc(2), 15);
    chk("stall_cnt CNT_W=16", get_sc(0), 20);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
